npu_requant_packer: RTL and testbench

- Sits directly downstream of the NPU sequencer's result stream.
- Each 64-bit input beat carries two signed int32 accumulators; four beats make one 8-lane core row.
- Each lane is requantized to int8: scale multiply, rounding arithmetic shift, optional ReLU, zero-point add, saturation.
- Each row of 8 bytes is packed into one 64-bit output beat toward the write-back DMA, cutting write-back bandwidth 4x.

---
 rtl/npu_requant_packer_if.sv | 22 ++
 rtl/npu_requant_packer.sv | 153 +++++++++++++++
 tb/tb_npu_requant_packer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_requant_packer_if.sv
// npu_requant_packer_if: input accumulator stream and packed int8 output stream.
interface npu_requant_packer_if #(
    parameter int AXI_WIDTH = 64
);
    logic [AXI_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [AXI_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/npu_requant_packer.sv
// npu_requant_packer: requantizes int32 accumulator lanes to int8 and packs
// each N-lane core row into a single output beat for write-back.
module npu_requant_packer #(
    parameter int N           = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int AXI_WIDTH   = 64,
    parameter int SCALE_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_start,
    input  logic [31:0]                   i_total_rows,
    input  logic signed [SCALE_WIDTH-1:0] i_cfg_scale,
    input  logic [4:0]                    i_cfg_shift,
    input  logic signed [7:0]             i_cfg_zero_point,
    input  logic                          i_cfg_relu_en,
    output logic                          o_busy,
    output logic                          o_done,
    npu_requant_packer_if.slave           bus
);
    localparam int LANES = AXI_WIDTH / ACC_WIDTH;
    localparam int BEATS = N / LANES;
    localparam int IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = ACC_WIDTH + SCALE_WIDTH;
    localparam int RW    = PW + 1;
    localparam logic [IDXW-1:0]      LAST_IDX = IDXW'(BEATS - 1);
    localparam logic signed [RW-1:0] SAT_HI   = RW'(127);
    localparam logic signed [RW-1:0] SAT_LO   = RW'(-128);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                        r_state, w_next;
    logic [31:0]                   r_total, r_rows_in, r_rows_out;
    logic signed [SCALE_WIDTH-1:0] r_scale;
    logic [4:0]                    r_shift;
    logic signed [7:0]             r_zp;
    logic                          r_relu;
    logic [IDXW-1:0]               r_beat_idx, r_s1_idx;
    logic                          r_s1_valid;
    logic signed [PW-1:0]          r_s1_prod [LANES];
    logic [N*8-1:0]                r_pack, w_row;
    logic [AXI_WIDTH-1:0]          r_out_data;
    logic                          r_out_valid, r_out_last, r_done;
    logic                          w_en, w_in_ready, w_accept, w_load, w_drain_ok;

    function automatic logic [7:0] requant(
        input logic signed [PW-1:0] p,
        input logic [4:0]           sh,
        input logic                 relu,
        input logic signed [7:0]    zp
    );
        logic signed [RW-1:0] r;
        r = RW'(p);
        if (sh != 5'd0)
            r = (r + (RW'(1) <<< (sh - 5'd1))) >>> sh;
        if (relu && r[RW-1])
            r = '0;
        r = r + RW'(zp);
        return (r > SAT_HI) ? 8'h7F : (r < SAT_LO) ? 8'h80 : r[7:0];
    endfunction

    // a stalled output beat freezes the whole pipeline and the input side
    assign w_en       = !(r_out_valid && !bus.out_ready);
    assign w_in_ready = (r_state == RUN) && w_en && (r_rows_in < r_total);
    assign w_accept   = w_in_ready && bus.in_valid;
    assign w_load     = w_en && r_s1_valid && (r_s1_idx == LAST_IDX);
    assign w_drain_ok = !r_s1_valid && !r_out_valid && (r_rows_out == r_total);

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && i_start)
            w_next = (i_total_rows == 32'd0) ? DRAIN : RUN;
        else if (r_state == RUN && r_rows_in == r_total)
            w_next = DRAIN;
        else if (r_state == DRAIN && w_drain_ok)
            w_next = IDLE;
    end

    // current S1 lanes merged into the partial row at their beat slot
    always_comb begin
        w_row = r_pack;
        for (int l = 0; l < LANES; l++)
            w_row[(int'(r_s1_idx) * LANES + l) * 8 +: 8] = requant(r_s1_prod[l], r_shift, r_relu, r_zp);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_total     <= '0;
            r_rows_in   <= '0;
            r_rows_out  <= '0;
            r_scale     <= '0;
            r_shift     <= '0;
            r_zp        <= '0;
            r_relu      <= 1'b0;
            r_beat_idx  <= '0;
            r_s1_idx    <= '0;
            r_s1_valid  <= 1'b0;
            for (int l = 0; l < LANES; l++)
                r_s1_prod[l] <= '0;
            r_pack      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == DRAIN) && w_drain_ok;
            if (r_state == IDLE && i_start) begin
                r_total    <= i_total_rows;
                r_scale    <= i_cfg_scale;
                r_shift    <= i_cfg_shift;
                r_zp       <= i_cfg_zero_point;
                r_relu     <= i_cfg_relu_en;
                r_rows_in  <= '0;
                r_rows_out <= '0;
                r_beat_idx <= '0;
            end
            if (w_accept) begin
                r_beat_idx <= (r_beat_idx == LAST_IDX) ? '0 : r_beat_idx + 1'b1;
                if (r_beat_idx == LAST_IDX)
                    r_rows_in <= r_rows_in + 32'd1;
            end
            if (w_en) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_idx <= r_beat_idx;
                    for (int l = 0; l < LANES; l++)
                        r_s1_prod[l] <= PW'($signed(bus.in_data[l*ACC_WIDTH +: ACC_WIDTH])) * PW'(r_scale);
                end
            end
            if (w_en && r_s1_valid)
                r_pack <= w_row;
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            if (w_load) begin
                r_out_data  <= AXI_WIDTH'(w_row);
                r_out_valid <= 1'b1;
                r_out_last  <= (r_rows_out + 32'd1 == r_total);
                r_rows_out  <= r_rows_out + 32'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign o_busy        = (r_state != IDLE);
    assign o_done        = r_done;
endmodule

// File: tb/tb_npu_requant_packer.sv
// tb_npu_requant_packer: randomized scenario bench with a plain-arithmetic
// requantization model; outputs sampled 1 time unit after the falling edge.
module tb_npu_requant_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] total_rows = '0;
    logic [15:0] cfg_scale = '0;
    logic [4:0]  cfg_shift = '0;
    logic [7:0]  cfg_zp = '0;
    logic        cfg_relu = 1'b0;
    logic        busy, done;

    npu_requant_packer_if #(.AXI_WIDTH(64)) bus ();

    npu_requant_packer #(.N(8), .ACC_WIDTH(32), .AXI_WIDTH(64), .SCALE_WIDTH(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (start),
        .i_total_rows     (total_rows),
        .i_cfg_scale      (cfg_scale),
        .i_cfg_shift      (cfg_shift),
        .i_cfg_zero_point (cfg_zp),
        .i_cfg_relu_en    (cfg_relu),
        .o_busy           (busy),
        .o_done           (done),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] beats[$];
    logic [63:0] got[$];
    logic        got_last[$];
    bit          saw_valid, timed_out;
    int          done_at, done_cnt, last_fire, first_lat, stall_err, inready_err;

    function automatic logic [7:0] ref_q(longint acc, longint sc, int sh, bit relu, longint zp);
        longint p;
        p = acc * sc;
        if (sh > 0)
            p = (p + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && p < 0)
            p = 0;
        p = p + zp;
        return (p > 127) ? 8'h7F : (p < -128) ? 8'h80 : 8'(p);
    endfunction

    function automatic logic [63:0] exp_row(int r, int sc, int sh, int zp, bit relu);
        logic [63:0]        row, b;
        logic signed [31:0] a;
        row = '0;
        for (int k = 0; k < 8; k++) begin
            b = beats[r*4 + k/2];
            a = (k % 2 == 1) ? b[63:32] : b[31:0];
            row[k*8 +: 8] = ref_q(longint'(a), sc, sh, relu, zp);
        end
        return row;
    endfunction

    function automatic logic [31:0] rand_acc();
        case ($urandom_range(3))
            0:       return 32'($urandom_range(4000)) - 32'd2000;
            1:       return $urandom;
            2:       return ($urandom_range(1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return 32'($urandom_range(300));
        endcase
    endfunction

    // Runs one job from the beats queue; config inputs are scrambled after start.
    task automatic run_job(input int total, input int sc, input int sh, input int zp, input bit relu,
                           input int vprob, input int rprob, input int stall, input bit restart);
        int          bi, acc_at, stall_left;
        bit          hold;
        logic [63:0] hold_d;
        bi = 0; acc_at = 0; stall_left = 0; hold = 0; hold_d = '0;
        got.delete(); got_last.delete();
        saw_valid = 0; timed_out = 1; done_at = -1; done_cnt = 0; last_fire = -1;
        first_lat = -1; stall_err = 0; inready_err = 0;
        @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            start = (n == 0) || (restart && n == 3);
            if (n == 0) begin
                total_rows = 32'(total); cfg_scale = 16'(sc); cfg_shift = 5'(sh);
                cfg_zp = 8'(zp); cfg_relu = relu;
            end else begin
                total_rows = (restart && n == 3) ? 32'(total + 2) : $urandom;
                cfg_scale = 16'($urandom); cfg_shift = 5'($urandom);
                cfg_zp = 8'($urandom); cfg_relu = 1'($urandom);
            end
            if (bi < beats.size()) begin
                bus.in_valid = ($urandom_range(99) < vprob);
                bus.in_data  = beats[bi];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = {$urandom, $urandom};
            end
            bus.out_ready = (stall > 0 && (!saw_valid || stall_left > 0)) ? 1'b0 : ($urandom_range(99) < rprob);
            if (stall_left > 0) stall_left--;
            #1;
            if (hold && (bus.out_valid !== 1'b1 || bus.out_data !== hold_d)) stall_err++;
            hold   = bus.out_valid && !bus.out_ready;
            hold_d = bus.out_data;
            if (bus.out_valid && !bus.out_ready && bus.in_ready) inready_err++;
            if (bus.out_valid && !saw_valid) begin
                saw_valid  = 1;
                first_lat  = n - acc_at;
                stall_left = stall - 1;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (bi == 3) acc_at = n;
                bi++;
            end
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data);
                got_last.push_back(bus.out_last);
                last_fire = n;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (done_at >= 0 && n >= done_at + 3) begin
                timed_out = 0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b1; total_rows = 32'd5; bus.in_valid = 1'b1; bus.in_data = {$urandom, $urandom};
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        n_vec++; if (bus.out_data !== 64'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        beats.delete();
        repeat (4) beats.push_back({32'(-1000), 32'(1000)});
        run_job(1, 1, 0, 0, 0, 100, 100, 0, 0);
        n_vec++; if (timed_out !== 0) begin n_err++; $display("FAIL sat_timeout: got %0d want 0", timed_out); end
        n_vec++; if (got.size() !== 1) begin n_err++; $display("FAIL sat_count: got %0d want 1", got.size()); end
        n_vec++; if ((got.size() > 0 ? got[0] : 64'hx) !== 64'h807F807F807F807F)
            begin n_err++; $display("FAIL sat_data: got %h want 807f807f807f807f", got.size() > 0 ? got[0] : 64'hx); end
        n_vec++; if ((got_last.size() > 0 ? got_last[0] : 1'bx) !== 1'b1)
            begin n_err++; $display("FAIL sat_last: got %b want 1", got_last.size() > 0 ? got_last[0] : 1'bx); end
        n_vec++; if (first_lat !== 2) begin n_err++; $display("FAIL sat_latency: got %0d want 2", first_lat); end
        n_vec++; if (done_at - last_fire !== 2) begin n_err++; $display("FAIL sat_done_lag: got %0d want 2", done_at - last_fire); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL sat_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_rounding();
        beats.delete();
        repeat (4) beats.push_back({32'(-5), 32'(300)});
        run_job(1, 3, 3, 0, 0, 100, 100, 0, 0);
        n_vec++; if ((got.size() > 0 ? got[0] : 64'hx) !== 64'hFE71FE71FE71FE71)
            begin n_err++; $display("FAIL round_s3: got %h want fe71fe71fe71fe71", got.size() > 0 ? got[0] : 64'hx); end
        run_job(1, 1, 1, 0, 0, 100, 100, 0, 0);
        n_vec++; if ((got.size() > 0 ? got[0] : 64'hx) !== 64'hFE7FFE7FFE7FFE7F)
            begin n_err++; $display("FAIL round_s1: got %h want fe7ffe7ffe7ffe7f", got.size() > 0 ? got[0] : 64'hx); end
    endtask

    task automatic test_relu_zp();
        beats.delete();
        repeat (4) beats.push_back({32'(10), 32'(-40)});
        run_job(1, 1, 0, 5, 1, 100, 100, 0, 0);
        n_vec++; if ((got.size() > 0 ? got[0] : 64'hx) !== 64'h0F050F050F050F05)
            begin n_err++; $display("FAIL relu_on: got %h want 0f050f050f050f05", got.size() > 0 ? got[0] : 64'hx); end
        run_job(1, 1, 0, 5, 0, 100, 100, 0, 0);
        n_vec++; if ((got.size() > 0 ? got[0] : 64'hx) !== 64'h0FDD0FDD0FDD0FDD)
            begin n_err++; $display("FAIL relu_off: got %h want 0fdd0fdd0fdd0fdd", got.size() > 0 ? got[0] : 64'hx); end
    endtask

    task automatic test_back_to_back();
        int sc;
        sc = int'($signed(16'($urandom)));
        beats.delete();
        repeat (16) beats.push_back({rand_acc(), rand_acc()});
        run_job(4, sc, 12, 3, 0, 100, 100, 0, 0);
        n_vec++; if (got.size() !== 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", got.size()); end
        for (int r = 0; r < 4; r++) begin
            n_vec++;
            if (r >= got.size() || got[r] !== exp_row(r, sc, 12, 3, 0))
                begin n_err++; $display("FAIL b2b_row%0d: got %h want %h", r, r < got.size() ? got[r] : 64'hx, exp_row(r, sc, 12, 3, 0)); end
        end
        n_vec++; if (last_fire !== 18) begin n_err++; $display("FAIL b2b_throughput: last beat at %0d want 18", last_fire); end
    endtask

    task automatic test_backpressure();
        int sc;
        sc = int'($signed(16'($urandom)));
        beats.delete();
        repeat (12) beats.push_back({rand_acc(), rand_acc()});
        run_job(3, sc, 9, -7, 1, 100, 100, 10, 0);
        n_vec++; if (got.size() !== 3) begin n_err++; $display("FAIL bp_count: got %0d want 3", got.size()); end
        for (int r = 0; r < 3; r++) begin
            n_vec++;
            if (r >= got.size() || got[r] !== exp_row(r, sc, 9, -7, 1) || got_last[r] !== (r == 2))
                begin n_err++; $display("FAIL bp_row%0d: got %h last %b want %h last %0d", r,
                    r < got.size() ? got[r] : 64'hx, r < got.size() ? got_last[r] : 1'bx, exp_row(r, sc, 9, -7, 1), r == 2); end
        end
        n_vec++; if (stall_err !== 0) begin n_err++; $display("FAIL bp_hold: %0d unstable cycles want 0", stall_err); end
        n_vec++; if (inready_err !== 0) begin n_err++; $display("FAIL bp_in_ready: %0d stalled cycles with in_ready want 0", inready_err); end
        n_vec++; if (done_at - last_fire !== 2) begin n_err++; $display("FAIL bp_done_lag: got %0d want 2", done_at - last_fire); end
    endtask

    task automatic test_zero_rows();
        beats.delete();
        run_job(0, 1, 0, 0, 0, 100, 100, 0, 0);
        n_vec++; if (done_at !== 2) begin n_err++; $display("FAIL zero_done_at: got %0d want 2", done_at); end
        n_vec++; if (saw_valid !== 0) begin n_err++; $display("FAIL zero_out_valid: got %0d want 0", saw_valid); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_while_busy();
        int sc;
        sc = int'($signed(16'($urandom)));
        beats.delete();
        repeat (8) beats.push_back({rand_acc(), rand_acc()});
        run_job(2, sc, 15, 0, 0, 60, 70, 0, 1);
        n_vec++; if (got.size() !== 2) begin n_err++; $display("FAIL restart_count: got %0d want 2", got.size()); end
        for (int r = 0; r < 2; r++) begin
            n_vec++;
            if (r >= got.size() || got[r] !== exp_row(r, sc, 15, 0, 0))
                begin n_err++; $display("FAIL restart_row%0d: got %h want %h", r, r < got.size() ? got[r] : 64'hx, exp_row(r, sc, 15, 0, 0)); end
        end
    endtask

    task automatic test_reset_mid_job();
        int acc, sc;
        acc = 0;
        @(negedge clk);
        start = 1'b1; total_rows = 32'd2; cfg_scale = 16'd1; cfg_shift = 5'd0; cfg_zp = 8'd0; cfg_relu = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 20 && acc < 2; n++) begin
            bus.in_valid = 1'b1; bus.in_data = {32'd100, 32'd90};
            #1;
            if (bus.in_ready) acc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        n_vec++; if (acc !== 2) begin n_err++; $display("FAIL midrst_beats: accepted %0d want 2", acc); end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if ({busy, bus.in_ready, bus.out_valid, bus.out_last, done} !== 5'b0 || bus.out_data !== 64'h0)
            begin n_err++; $display("FAIL midrst_outputs: busy %b rdy %b vld %b last %b done %b data %h want all 0",
                busy, bus.in_ready, bus.out_valid, bus.out_last, done, bus.out_data); end
        rst_n = 1'b1;
        sc = int'($signed(16'($urandom)));
        beats.delete();
        repeat (4) beats.push_back({rand_acc(), rand_acc()});
        run_job(1, sc, 6, 1, 0, 100, 100, 0, 0);
        n_vec++; if (got.size() !== 1) begin n_err++; $display("FAIL midrst_count: got %0d want 1", got.size()); end
        n_vec++; if ((got.size() > 0 ? got[0] : 64'hx) !== exp_row(0, sc, 6, 1, 0))
            begin n_err++; $display("FAIL midrst_row: got %h want %h", got.size() > 0 ? got[0] : 64'hx, exp_row(0, sc, 6, 1, 0)); end
    endtask

    task automatic test_random();
        int rows, sc, sh, zp;
        bit relu;
        for (int j = 0; j < 8; j++) begin
            rows = $urandom_range(1, 5);
            sc   = int'($signed(16'($urandom)));
            sh   = $urandom_range(31);
            zp   = int'($signed(8'($urandom)));
            relu = 1'($urandom_range(1));
            beats.delete();
            repeat (rows * 4) beats.push_back({rand_acc(), rand_acc()});
            run_job(rows, sc, sh, zp, relu, 70, 60, 0, 0);
            n_vec++; if (timed_out !== 0 || got.size() !== rows)
                begin n_err++; $display("FAIL rand%0d_count: got %0d rows timeout %0d want %0d", j, got.size(), timed_out, rows); end
            for (int r = 0; r < rows; r++) begin
                n_vec++;
                if (r >= got.size() || got[r] !== exp_row(r, sc, sh, zp, relu) || got_last[r] !== (r == rows - 1))
                    begin n_err++; $display("FAIL rand%0d_row%0d: got %h last %b want %h", j, r,
                        r < got.size() ? got[r] : 64'hx, r < got.size() ? got_last[r] : 1'bx, exp_row(r, sc, sh, zp, relu)); end
            end
            n_vec++; if (stall_err !== 0 || inready_err !== 0 || done_cnt !== 1)
                begin n_err++; $display("FAIL rand%0d_handshake: hold %0d ready %0d done %0d want 0 0 1", j, stall_err, inready_err, done_cnt); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_saturation();
        test_rounding();
        test_relu_zp();
        test_back_to_back();
        test_backpressure();
        test_zero_rows();
        test_start_while_busy();
        test_reset_mid_job();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
